// File: rtl/delta_decode_accum_pkg.sv
// Shared types, constants and arithmetic helpers for the delta decode/encode datapaths.
package delta_decode_accum_pkg;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned DROP_W = 8;

    localparam logic [WIDTH-1:0] SIGNED_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SIGNED_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Signed overflow: operands share a sign and the result sign differs.
    function automatic logic add_ovf(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b,
                                     input logic [WIDTH-1:0] sum);
        return (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    endfunction

    // Two's complement add clamped to the signed range.
    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] sum;
        sum = a + b;
        if (add_ovf(a, b, sum)) begin
            return a[WIDTH-1] ? SIGNED_MIN : SIGNED_MAX;
        end
        return sum;
    endfunction

endpackage

// File: rtl/delta_out_stage.sv
// Output register stage: holds sample/first under backpressure, generates upstream ready.
module delta_out_stage
    import delta_decode_accum_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_sample,
    input  logic             load_first,
    input  logic             out_ready,
    output logic             in_ready_c,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_sample,
    output logic             out_first
);

    // Upstream may push whenever the register is empty or draining this cycle.
    assign in_ready_c = !out_valid || out_ready;

    // Load a new beat, otherwise drop valid once consumed; payload holds until next load.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_sample <= '0;
            out_first  <= 1'b0;
        end else if (load) begin
            out_valid  <= 1'b1;
            out_sample <= load_sample;
            out_first  <= load_first;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/delta_decode_accum.sv
// Rebuilds a sample stream from signed deltas by running accumulation.
// Build option: define DELTA_ACC_SAT_EN for saturating accumulation instead of wrap-around.
module delta_decode_accum
    import delta_decode_accum_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    input  logic [WIDTH-1:0]  io_in_delta,
    input  logic              io_in_first,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic [WIDTH-1:0]  io_out_sample,
    output logic              io_out_first,
    output logic              io_overflow,
    output logic [DROP_W-1:0] io_drop_count
);

    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [DROP_W-1:0]  drop_q, drop_d;
    logic               load;
    logic [WIDTH-1:0]   load_sample;
    logic               load_first;
    logic               in_ready_c;
    logic               accept;
    logic [WIDTH-1:0]   sum;
    logic               sum_ovf;

    assign accept      = io_in_valid && in_ready_c;
    assign io_in_ready = in_ready_c;
    assign sum         = acc_q + io_in_delta;
    assign sum_ovf     = add_ovf(acc_q, io_in_delta, sum);

    // State, accumulator, sticky overflow and drop counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state and datapath: seed, accumulate or drop the accepted beat.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        drop_d      = drop_q;
        load        = 1'b0;
        load_sample = acc_q;
        load_first  = 1'b0;
        if (accept) begin
            if (io_in_first) begin
                // A seed always wins, including over a same-cycle overflow.
                state_d     = RUN;
                acc_d       = io_in_delta;
                ovf_d       = 1'b0;
                load        = 1'b1;
                load_sample = io_in_delta;
                load_first  = 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (drop_q != DROP_MAX) begin
                            drop_d = drop_q + DROP_W'(1);
                        end
                    end
                    RUN: begin
`ifdef DELTA_ACC_SAT_EN
                        acc_d = sat_add(acc_q, io_in_delta);
`else
                        acc_d = sum;
`endif
                        ovf_d       = ovf_q || sum_ovf;
                        load        = 1'b1;
                        load_sample = acc_d;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    assign io_overflow   = ovf_q;
    assign io_drop_count = drop_q;

    delta_out_stage u_out_stage (
        .clock       (clock),
        .reset       (reset),
        .load        (load),
        .load_sample (load_sample),
        .load_first  (load_first),
        .out_ready   (io_out_ready),
        .in_ready_c  (in_ready_c),
        .out_valid   (io_out_valid),
        .out_sample  (io_out_sample),
        .out_first   (io_out_first)
    );

endmodule

// File: tb/tb_delta_decode_accum.sv
// Bench for delta_decode_accum: directed plan steps plus random traffic against an integer model.
// Honours DELTA_ACC_SAT_EN when the bundle is built with it.
module tb_delta_decode_accum;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [15:0] io_in_delta;
    logic        io_in_first;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [15:0] io_out_sample;
    logic        io_out_first;
    logic        io_overflow;
    logic [7:0]  io_drop_count;

    int checks = 0;
    int errors = 0;

    // Behavioural model: plain integers, no register-level structure.
    bit          m_seeded;
    int          m_acc;
    bit          m_valid;
    logic [15:0] m_sample;
    bit          m_first;
    bit          m_ovf;
    int          m_drops;

    delta_decode_accum dut (
        .clock         (clock),
        .reset         (reset),
        .io_in_valid   (io_in_valid),
        .io_in_ready   (io_in_ready),
        .io_in_delta   (io_in_delta),
        .io_in_first   (io_in_first),
        .io_out_valid  (io_out_valid),
        .io_out_ready  (io_out_ready),
        .io_out_sample (io_out_sample),
        .io_out_first  (io_out_first),
        .io_overflow   (io_overflow),
        .io_drop_count (io_drop_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_seeded = 0; m_acc = 0; m_valid = 0; m_sample = 16'h0;
        m_first = 0; m_ovf = 0; m_drops = 0;
    endtask

    task automatic model_edge(input bit v, input bit f, input logic [15:0] d, input bit r);
        bit rdy;
        int s;
        bit loaded;
        rdy = !m_valid || r;
        loaded = 0;
        if (v && rdy) begin
            if (f) begin
                m_seeded = 1; m_acc = int'($signed(d)); m_ovf = 0;
                m_sample = d; m_first = 1; loaded = 1;
            end else if (!m_seeded) begin
                if (m_drops < 255) m_drops++;
            end else begin
                s = m_acc + int'($signed(d));
                if (s > 32767 || s < -32768) begin
                    m_ovf = 1;
`ifdef DELTA_ACC_SAT_EN
                    s = (s > 32767) ? 32767 : -32768;
`else
                    s = (s > 32767) ? s - 65536 : s + 65536;
`endif
                end
                m_acc = s; m_sample = 16'(s); m_first = 0; loaded = 1;
            end
        end
        if (loaded) m_valid = 1;
        else if (r) m_valid = 0;
    endtask

    task automatic compare_all();
        chk("out_valid", 32'(io_out_valid), 32'(m_valid));
        if (m_valid) begin
            chk("out_sample", 32'(io_out_sample), 32'(m_sample));
            chk("out_first", 32'(io_out_first), 32'(m_first));
        end
        chk("overflow", 32'(io_overflow), 32'(m_ovf));
        chk("drop_count", 32'(io_drop_count), 32'(m_drops));
    endtask

    // One clock: drive at edge+1, check ready mid-cycle, update model at edge, compare after.
    task automatic step(input bit v, input bit f, input logic [15:0] d, input bit r);
        io_in_valid = v; io_in_first = f; io_in_delta = d; io_out_ready = r;
        #1;
        chk("in_ready", 32'(io_in_ready), 32'(!m_valid || r));
        @(posedge clock);
        model_edge(v, f, d, r);
        #1;
        compare_all();
    endtask

    initial begin
        logic [15:0] held;
        logic [15:0] exp_wrap;
        reset = 1'b1;
        io_in_valid = 0; io_in_first = 0; io_in_delta = 16'h0; io_out_ready = 0;
        model_reset();
        @(posedge clock);
        #1;
        chk("reset_valid", 32'(io_out_valid), 32'd0);
        chk("reset_sample", 32'(io_out_sample), 32'd0);
        chk("reset_first", 32'(io_out_first), 32'd0);
        chk("reset_ovf", 32'(io_overflow), 32'd0);
        chk("reset_drop", 32'(io_drop_count), 32'd0);
        reset = 1'b0;

        // Unseeded beats are dropped and counted.
        step(1, 0, 16'h0005, 1);
        step(1, 0, 16'h1234, 1);
        step(1, 0, 16'hFFFF, 1);
        chk("drop3_valid", 32'(io_out_valid), 32'd0);
        chk("drop3_count", 32'(io_drop_count), 32'd3);
        step(1, 1, 16'h0000, 1);
        chk("seed0_sample", 32'(io_out_sample), 32'h0);
        chk("seed0_first", 32'(io_out_first), 32'd1);

        // Seed then deltas, one sample per cycle.
        step(1, 1, 16'h0010, 1);
        chk("seq_seed", 32'(io_out_sample), 32'h10);
        chk("seq_seed_first", 32'(io_out_first), 32'd1);
        step(1, 0, 16'h0005, 1);
        chk("seq_plus5", 32'(io_out_sample), 32'h15);
        step(1, 0, 16'hFFFD, 1);
        chk("seq_minus3", 32'(io_out_sample), 32'h12);
        chk("seq_minus3_first", 32'(io_out_first), 32'd0);

        // Backpressure: held output, no ready, then resume without bubble.
        held = io_out_sample;
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 16'h0001, 0);
            chk("bp_ready", 32'(io_in_ready), 32'd0);
            chk("bp_hold", 32'(io_out_sample), 32'(held));
            chk("bp_valid", 32'(io_out_valid), 32'd1);
        end
        step(1, 0, 16'h0001, 1);
        chk("bp_resume1", 32'(io_out_sample), 32'h13);
        step(1, 0, 16'h0001, 1);
        chk("bp_resume2", 32'(io_out_sample), 32'h14);

        // Overflow at the positive limit.
        step(1, 1, 16'h7FFF, 1);
        step(1, 0, 16'h0001, 1);
`ifdef DELTA_ACC_SAT_EN
        exp_wrap = 16'h7FFF;
`else
        exp_wrap = 16'h8000;
`endif
        chk("ovf_sample", 32'(io_out_sample), 32'(exp_wrap));
        chk("ovf_flag", 32'(io_overflow), 32'd1);
        step(1, 0, 16'h0000, 1);
        chk("ovf_sticky", 32'(io_overflow), 32'd1);
        step(1, 1, 16'h0003, 1);
        chk("ovf_cleared", 32'(io_overflow), 32'd0);

        // Re-seed mid-frame.
        step(1, 1, 16'h0100, 1);
        step(1, 1, 16'h0042, 1);
        chk("reseed_sample", 32'(io_out_sample), 32'h42);
        chk("reseed_first", 32'(io_out_first), 32'd1);
        step(1, 0, 16'h0001, 1);
        chk("reseed_next", 32'(io_out_sample), 32'h43);

        // Async reset between edges while a sample is valid.
        step(1, 0, 16'h0001, 0);
        chk("pre_rst_valid", 32'(io_out_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(io_out_valid), 32'd0);
        chk("async_rst_drop", 32'(io_drop_count), 32'd0);
        model_reset();
        io_in_valid = 0;
        @(posedge clock);
        #1 reset = 1'b0;
        step(1, 0, 16'h0007, 1);
        chk("post_rst_valid", 32'(io_out_valid), 32'd0);
        chk("post_rst_drop", 32'(io_drop_count), 32'd1);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [15:0] d;
            bit v, f, r;
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 0) d = 16'($urandom);
            else d = 16'($urandom_range(0, 63)) - 16'd32;
            step(v, f, d, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
